id_issue_buffer: RTL and testbench

ID_ISSUE_BUFFER -- requirements
Module: id_issue_buffer

---
 rtl/ariane_pkg.sv | 36 +++
 rtl/id_issue_buffer.sv | 125 ++++++++++++
 tb/tb_id_issue_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared decode/issue types and ID-stage sizing constants.
//   fu_t               - functional unit selector carried by a decoded entry
//   scoreboard_entry_t - decoded instruction as handed from ID to issue
//   IdBufDepth         - default depth of the ID issue buffer
//   IdBufCfMax         - default number of control-flow entries held at once
package ariane_pkg;

    localparam int unsigned IdBufDepth = 4;
    localparam int unsigned IdBufCfMax = 1;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  trans_id;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;
        logic        use_imm;
        logic        use_pc;
        logic        is_compressed;
    } scoreboard_entry_t;

endpackage

// File: rtl/id_issue_buffer.sv
// id_issue_buffer: circular FIFO of decoded entries between decode and issue.
// Limits the number of buffered control-flow entries to CF_MAX.
//   clk_i                - clock
//   rst_ni               - asynchronous active-low reset
//   flush_i              - discard all buffered entries (effective next cycle)
//   decoded_entry_i      - decoder output entry
//   is_ctrl_flow_i       - decoder entry is control flow
//   decoded_valid_i      - decoder entry valid
//   fetch_entry_ready_o  - decoder entry accepted this cycle (combinational)
//   issue_entry_o        - oldest buffered entry
//   issue_entry_valid_o  - issue_entry_o valid
//   is_ctrl_flow_o       - oldest entry is control flow
//   issue_instr_ack_i    - issue stage consumes the oldest entry
//   usage_o              - number of valid entries
//   cf_pending_o         - number of buffered control-flow entries
module id_issue_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH  = ariane_pkg::IdBufDepth,
    parameter int unsigned CF_MAX = ariane_pkg::IdBufCfMax
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  scoreboard_entry_t           decoded_entry_i,
    input  logic                        is_ctrl_flow_i,
    input  logic                        decoded_valid_i,
    output logic                        fetch_entry_ready_o,
    output scoreboard_entry_t           issue_entry_o,
    output logic                        issue_entry_valid_o,
    output logic                        is_ctrl_flow_o,
    input  logic                        issue_instr_ack_i,
    output logic [$clog2(DEPTH):0]      usage_o,
    output logic [$clog2(CF_MAX):0]     cf_pending_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned UsageW = $clog2(DEPTH) + 1;
    localparam int unsigned CfW    = $clog2(CF_MAX) + 1;

    localparam logic [UsageW-1:0] DepthVal = UsageW'(DEPTH);
    localparam logic [CfW-1:0]    CfMaxVal = CfW'(CF_MAX);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
        $error("id_issue_buffer: DEPTH must be a power of two >= 2");
    end
    if ((CF_MAX < 1) || (CF_MAX > DEPTH)) begin : gen_bad_cf_max
        $error("id_issue_buffer: CF_MAX must be in 1..DEPTH");
    end

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              cf;
    } buf_entry_t;

    buf_entry_t        mem [DEPTH];
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW-1:0]   wr_ptr;
    logic [UsageW-1:0] usage;
    logic [CfW-1:0]    cf_cnt;

    logic push;
    logic pop;
    logic space_ok;
    logic cf_ok;
    logic cf_push;
    logic cf_pop;

    assign issue_entry_valid_o = (usage != '0);
    assign issue_entry_o       = mem[rd_ptr].sbe;
    // Stale storage after a flush may still hold a CF bit; only report it for a live head.
    assign is_ctrl_flow_o      = issue_entry_valid_o && mem[rd_ptr].cf;
    assign usage_o             = usage;
    assign cf_pending_o        = cf_cnt;

    assign pop      = issue_instr_ack_i && issue_entry_valid_o;
    // A full buffer (or full CF budget) can still accept when the head leaves this cycle.
    assign space_ok = (usage < DepthVal) || pop;
    assign cf_ok    = !is_ctrl_flow_i || (cf_cnt < CfMaxVal) || (pop && is_ctrl_flow_o);

    assign fetch_entry_ready_o = decoded_valid_i && space_ok && cf_ok && !flush_i;
    assign push                = fetch_entry_ready_o;

    assign cf_push = push && is_ctrl_flow_i;
    assign cf_pop  = pop && is_ctrl_flow_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            usage  <= '0;
            cf_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            usage  <= '0;
            cf_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr].sbe <= decoded_entry_i;
                mem[wr_ptr].cf  <= is_ctrl_flow_i;
                wr_ptr          <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end

            case ({push, pop})
                2'b10:   usage <= usage + UsageW'(1);
                2'b01:   usage <= usage - UsageW'(1);
                default: usage <= usage;
            endcase

            case ({cf_push, cf_pop})
                2'b10:   cf_cnt <= cf_cnt + CfW'(1);
                2'b01:   cf_cnt <= cf_cnt - CfW'(1);
                default: cf_cnt <= cf_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_id_issue_buffer.sv
// tb_id_issue_buffer: directed + randomized checks of id_issue_buffer against
// a queue-based reference model of the buffer contents.
module tb_id_issue_buffer;
    import ariane_pkg::*;

    localparam int unsigned DEPTH  = ariane_pkg::IdBufDepth;
    localparam int unsigned CF_MAX = ariane_pkg::IdBufCfMax;

    logic                        clk_i;
    logic                        rst_ni;
    logic                        flush_i;
    scoreboard_entry_t           decoded_entry_i;
    logic                        is_ctrl_flow_i;
    logic                        decoded_valid_i;
    logic                        fetch_entry_ready_o;
    scoreboard_entry_t           issue_entry_o;
    logic                        issue_entry_valid_o;
    logic                        is_ctrl_flow_o;
    logic                        issue_instr_ack_i;
    logic [$clog2(DEPTH):0]      usage_o;
    logic [$clog2(CF_MAX):0]     cf_pending_o;

    id_issue_buffer #(
        .DEPTH  (DEPTH),
        .CF_MAX (CF_MAX)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .decoded_entry_i     (decoded_entry_i),
        .is_ctrl_flow_i      (is_ctrl_flow_i),
        .decoded_valid_i     (decoded_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .issue_entry_o       (issue_entry_o),
        .issue_entry_valid_o (issue_entry_valid_o),
        .is_ctrl_flow_o      (is_ctrl_flow_o),
        .issue_instr_ack_i   (issue_instr_ack_i),
        .usage_o             (usage_o),
        .cf_pending_o        (cf_pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] pc;
        logic        cf;
    } ref_t;

    ref_t        q[$];
    int unsigned pc_ctr;
    int unsigned vectors;
    int unsigned miscompares;

    function automatic int unsigned cf_in_queue();
        int unsigned n = 0;
        foreach (q[i]) if (q[i].cf) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with what the model says the buffer holds.
    task automatic check_outputs(input logic exp_ready);
        chk("ready", 64'(fetch_entry_ready_o), 64'(exp_ready));
        chk("valid", 64'(issue_entry_valid_o), 64'(q.size() != 0));
        chk("usage", 64'(usage_o), 64'(q.size()));
        chk("cf_pending", 64'(cf_pending_o), 64'(cf_in_queue()));
        if (q.size() != 0) begin
            chk("head_pc", issue_entry_o.pc, q[0].pc);
            chk("head_cf", 64'(is_ctrl_flow_o), 64'(q[0].cf));
        end else begin
            chk("head_cf_empty", 64'(is_ctrl_flow_o), 64'd0);
        end
    endtask

    // One clock cycle: drive at the negedge, check mid-phase, update model at posedge.
    task automatic cycle(input logic v, input logic cf, input logic ack, input logic fl);
        logic pop_e;
        logic ready_e;
        decoded_valid_i         = v;
        is_ctrl_flow_i          = cf;
        issue_instr_ack_i       = ack;
        flush_i                 = fl;
        decoded_entry_i         = '0;
        decoded_entry_i.pc      = 64'h8000_0000 + 64'(pc_ctr) * 64'd4;
        decoded_entry_i.fu      = cf ? CTRL_FLOW : ALU;
        decoded_entry_i.rd      = 5'($urandom);
        decoded_entry_i.valid   = 1'b1;
        #1;
        pop_e   = ack && (q.size() != 0);
        ready_e = v && !fl
                  && ((q.size() < DEPTH) || pop_e)
                  && (!cf || (cf_in_queue() < CF_MAX) || (pop_e && q[0].cf));
        check_outputs(ready_e);
        @(posedge clk_i);
        if (fl) begin
            q.delete();
        end else begin
            if (pop_e) void'(q.pop_front());
            if (ready_e) begin
                q.push_back('{pc: 64'h8000_0000 + 64'(pc_ctr) * 64'd4, cf: cf});
                pc_ctr++;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drained", 64'(usage_o), 64'd0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        pc_ctr            = 0;
        rst_ni            = 1'b0;
        flush_i           = 1'b0;
        decoded_entry_i   = '0;
        is_ctrl_flow_i    = 1'b0;
        decoded_valid_i   = 1'b0;
        issue_instr_ack_i = 1'b0;

        // Reset state
        #2;
        check_outputs(1'b0);
        chk("reset_entry_pc", issue_entry_o.pc, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill: five offers with no ack, fifth must stall
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill_usage", 64'(usage_o), 64'(DEPTH));

        // Full + ack + valid: accepted, usage stays full, head advances to entry 2
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("full_ack_usage", 64'(usage_o), 64'(DEPTH));
        chk("full_ack_head", issue_entry_o.pc, 64'h8000_0004);

        // Random order test, at least 16 entries through the buffer
        for (int i = 0; i < 48; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Control-flow limit: branch A, stalled branch B, non-CF passes, ack A admits B
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("cf_stall_pending", 64'(cf_pending_o), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("cf_noncf_usage", 64'(usage_o), 64'd2);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("cf_b_pending", 64'(cf_pending_o), 64'd1);
        drain();

        // Flush with three entries and concurrent push/ack
        for (int i = 0; i < 3; i++) cycle(1'b1, i == 1, 1'b0, 1'b0);
        chk("pre_flush_usage", 64'(usage_o), 64'd3);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("post_flush_usage", 64'(usage_o), 64'd0);
        chk("post_flush_valid", 64'(issue_entry_valid_o), 64'd0);
        chk("post_flush_cf", 64'(cf_pending_o), 64'd0);

        // Wrap-around: restart PC sequence, ten push/pop cycles
        pc_ctr = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrap_head", issue_entry_o.pc, 64'h8000_0024);
        drain();

        // Asynchronous reset mid-fill, between clock edges
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_usage", 64'(usage_o), 64'd2);
        decoded_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        q.delete();
        check_outputs(1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Ack on empty buffer: no state change
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_outputs(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
